// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM host sequencer: controller command codes,
// sequencer FSM states and default timing values.
package sdram_pkg;

    localparam logic [2:0] CMD_NOP       = 3'b000;
    localparam logic [2:0] CMD_READA     = 3'b001;
    localparam logic [2:0] CMD_WRITEA    = 3'b010;
    localparam logic [2:0] CMD_REFRESH   = 3'b011;
    localparam logic [2:0] CMD_PRECHARGE = 3'b100;
    localparam logic [2:0] CMD_LOAD_MODE = 3'b101;
    localparam logic [2:0] CMD_LOAD_REG1 = 3'b110;

    typedef enum logic [3:0] {
        StInitWait,
        StReg1,
        StPre,
        StRef1,
        StRef2,
        StLmr,
        StIdle,
        StRef,
        StRead,
        StWrite
    } seq_state_e;

    localparam int unsigned DEF_ASIZE      = 25;
    localparam int unsigned DEF_DSIZE      = 16;
    localparam int unsigned DEF_INIT_WAIT  = 20000;
    localparam int unsigned DEF_REF_PERIOD = 780;
    localparam int unsigned DEF_T_RD       = 8;
    localparam int unsigned DEF_RD_LAT     = 6;
    localparam int unsigned DEF_T_WR       = 8;
    localparam int unsigned DEF_T_REF      = 10;
    localparam int unsigned DEF_T_PRE      = 4;
    localparam int unsigned DEF_T_LMR      = 4;

    localparam logic [24:0] DEF_REG1_WORD = 25'h000_0125;
    localparam logic [24:0] DEF_MODE_WORD = 25'h000_0030;

    // Address bit that selects all banks on PRECHARGE.
    localparam int unsigned PRE_ALL_BIT = 10;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Free-running refresh interval counter; raises a single sticky pending flag per
// interval until the sequencer services it.
module sdram_refresh_timer
    import sdram_pkg::*;
#(
    parameter int unsigned REF_PERIOD = DEF_REF_PERIOD
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic pending_o
);

    localparam int unsigned CntW = (REF_PERIOD > 2) ? $clog2(REF_PERIOD) : 1;
    localparam logic [CntW-1:0] WrapVal = CntW'(REF_PERIOD - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            pending_q, pending_d;
    logic            wrap;

    always_comb begin
        wrap  = en_i && (cnt_q == WrapVal);
        cnt_d = cnt_q + 1'b1;
        if (!en_i || wrap) begin
            cnt_d = '0;
        end
        // A wrap while already pending still leaves only one refresh owed.
        pending_d = en_i && (wrap || (pending_q && !clr_i));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/sdram_host_sequencer.sv
// Host-side command generator for the SDRAM controller: power-up sequence, periodic
// refresh and single-beat client reads/writes, with all spacing set by cycle counts.
module sdram_host_sequencer
    import sdram_pkg::*;
#(
    parameter int unsigned     ASIZE      = DEF_ASIZE,
    parameter int unsigned     DSIZE      = DEF_DSIZE,
    parameter int unsigned     INIT_WAIT  = DEF_INIT_WAIT,
    parameter int unsigned     REF_PERIOD = DEF_REF_PERIOD,
    parameter logic [ASIZE-1:0] REG1_WORD = ASIZE'(DEF_REG1_WORD),
    parameter logic [ASIZE-1:0] MODE_WORD = ASIZE'(DEF_MODE_WORD),
    parameter int unsigned     T_RD       = DEF_T_RD,
    parameter int unsigned     RD_LAT     = DEF_RD_LAT,
    parameter int unsigned     T_WR       = DEF_T_WR,
    parameter int unsigned     T_REF      = DEF_T_REF,
    parameter int unsigned     T_PRE      = DEF_T_PRE,
    parameter int unsigned     T_LMR      = DEF_T_LMR
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic               req_we_i,
    input  logic [ASIZE-1:0]   req_addr_i,
    input  logic [DSIZE-1:0]   req_wdata_i,
    input  logic [DSIZE/8-1:0] req_dm_i,
    output logic               rsp_valid_o,
    output logic [DSIZE-1:0]   rsp_rdata_o,
    output logic               init_done_o,
    output logic [2:0]         ctl_cmd_o,
    output logic [ASIZE-1:0]   ctl_addr_o,
    output logic [DSIZE-1:0]   ctl_datain_o,
    output logic [DSIZE/8-1:0] ctl_dm_o,
    input  logic [DSIZE-1:0]   ctl_dataout_i
);

    localparam int unsigned BusyMax = max_u(max_u(max_u(INIT_WAIT, T_RD), max_u(T_WR, T_REF)),
                                            max_u(T_PRE, T_LMR));
    localparam int unsigned CntW = $clog2(BusyMax + 1);
    // Busy count in effect on the cycle read data is valid at the controller.
    localparam logic [CntW-1:0]  RdCapture  = CntW'(T_RD - 1 - RD_LAT);
    localparam logic [ASIZE-1:0] PreAllAddr = ASIZE'(1) << PRE_ALL_BIT;

    seq_state_e         state_q, state_d;
    logic [CntW-1:0]    busy_q, busy_d;
    logic [2:0]         cmd_q, cmd_d;
    logic [ASIZE-1:0]   addr_q, addr_d;
    logic [DSIZE-1:0]   datain_q, datain_d;
    logic [DSIZE/8-1:0] dm_q, dm_d;
    logic               init_done_q, init_done_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DSIZE-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic               ref_pending;
    logic               ref_clr;
    logic               req_ready;
    logic               busy_done;
    logic               issue;
    logic [2:0]         issue_cmd;
    logic [ASIZE-1:0]   issue_addr;
    int unsigned        issue_t;

    sdram_refresh_timer #(
        .REF_PERIOD(REF_PERIOD)
    ) u_refresh_timer (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .en_i     (init_done_q),
        .clr_i    (ref_clr),
        .pending_o(ref_pending)
    );

    assign req_ready = (state_q == StIdle) && !ref_pending && init_done_q;

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        cmd_d       = CMD_NOP;
        addr_d      = addr_q;
        datain_d    = datain_q;
        dm_d        = dm_q;
        init_done_d = init_done_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        ref_clr     = 1'b0;
        issue       = 1'b0;
        issue_cmd   = CMD_NOP;
        issue_addr  = '0;
        issue_t     = 1;

        busy_done = (busy_q == '0);
        if (!busy_done) begin
            busy_d = busy_q - 1'b1;
        end

        unique case (state_q)
            StInitWait: begin
                if (busy_done) begin
                    state_d    = StReg1;
                    issue      = 1'b1;
                    issue_cmd  = CMD_LOAD_REG1;
                    issue_addr = REG1_WORD;
                    issue_t    = T_LMR;
                end
            end
            StReg1: begin
                if (busy_done) begin
                    state_d    = StPre;
                    issue      = 1'b1;
                    issue_cmd  = CMD_PRECHARGE;
                    issue_addr = PreAllAddr;
                    issue_t    = T_PRE;
                end
            end
            StPre: begin
                if (busy_done) begin
                    state_d   = StRef1;
                    issue     = 1'b1;
                    issue_cmd = CMD_REFRESH;
                    issue_t   = T_REF;
                end
            end
            StRef1: begin
                if (busy_done) begin
                    state_d   = StRef2;
                    issue     = 1'b1;
                    issue_cmd = CMD_REFRESH;
                    issue_t   = T_REF;
                end
            end
            StRef2: begin
                if (busy_done) begin
                    state_d    = StLmr;
                    issue      = 1'b1;
                    issue_cmd  = CMD_LOAD_MODE;
                    issue_addr = MODE_WORD;
                    issue_t    = T_LMR;
                end
            end
            StLmr: begin
                if (busy_done) begin
                    state_d     = StIdle;
                    init_done_d = 1'b1;
                end
            end
            StIdle: begin
                if (ref_pending) begin
                    state_d   = StRef;
                    issue     = 1'b1;
                    issue_cmd = CMD_REFRESH;
                    issue_t   = T_REF;
                    ref_clr   = 1'b1;
                end else if (req_valid_i && req_ready) begin
                    issue      = 1'b1;
                    issue_addr = req_addr_i;
                    if (req_we_i) begin
                        state_d   = StWrite;
                        issue_cmd = CMD_WRITEA;
                        issue_t   = T_WR;
                    end else begin
                        state_d   = StRead;
                        issue_cmd = CMD_READA;
                        issue_t   = T_RD;
                    end
                end
            end
            StRead: begin
                if (busy_q == RdCapture) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = ctl_dataout_i;
                end
                if (busy_done) begin
                    state_d = StIdle;
                end
            end
            StRef, StWrite: begin
                if (busy_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StInitWait;
        endcase

        if (issue) begin
            cmd_d    = issue_cmd;
            addr_d   = issue_addr;
            busy_d   = CntW'(issue_t - 1);
            datain_d = '0;
            dm_d     = '0;
            if (issue_cmd == CMD_WRITEA) begin
                datain_d = req_wdata_i;
                dm_d     = req_dm_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StInitWait;
            busy_q      <= CntW'(INIT_WAIT - 1);
            cmd_q       <= CMD_NOP;
            addr_q      <= '0;
            datain_q    <= '0;
            dm_q        <= '0;
            init_done_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            datain_q    <= datain_d;
            dm_q        <= dm_d;
            init_done_q <= init_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready_o  = req_ready;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_rdata_o  = rsp_rdata_q;
    assign init_done_o  = init_done_q;
    assign ctl_cmd_o    = cmd_q;
    assign ctl_addr_o   = addr_q;
    assign ctl_datain_o = datain_q;
    assign ctl_dm_o     = dm_q;

endmodule
